alu_exec_unit: RTL and testbench

Execution datapath that responds to the control unit's `load_alu`/`alu_op` commands. It performs 8-bit unsigned ADD/SUB in one cycle and MUL/DIV as 8-step iterative shift-add and restoring-divide sequences. It holds each result until the next accepted command and signals completion with a one-cycle `done` pulse. It sits between the control unit and the operand/result registers of the 8-bit ALU.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_muldiv_core.sv | 104 ++++++++++
 rtl/alu_exec_unit.sv | 132 +++++++++++++
 tb/tb_alu_exec_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and FSM state type for the 8-bit ALU execution unit
package alu_pkg;

  // Operation encodings, shared with the control unit
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// rtl/alu_muldiv_core.sv - iterative shift-add multiplier / restoring divider sharing one adder
import alu_pkg::*;

module alu_muldiv_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finish,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  // hi holds the product high half (MUL) or remainder (DIV);
  // lo holds the multiplier being shifted out (MUL) or dividend/quotient (DIV)
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_div_q, op_div_d;

  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   step_y;
  logic [WIDTH+1:0] step_r;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  // One iteration step: a single W+2 bit adder that adds for MUL and subtracts for DIV
  always_comb begin
    step_x  = '0;
    step_y  = '0;
    step_r  = '0;
    hi_step = hi_q;
    lo_step = lo_q;
    if (op_div_q) begin
      // Partial remainder is shifted left by one and brought to W+1 bits
      step_x = {hi_q, lo_q[WIDTH-1]};
      step_y = {1'b0, opnd_q};
      step_r = {1'b0, step_x} - {1'b0, step_y};
      if (step_r[WIDTH+1]) begin
        hi_step = step_x[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_step = step_r[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_x  = {1'b0, hi_q};
      step_y  = lo_q[0] ? {1'b0, opnd_q} : '0;
      step_r  = {1'b0, step_x} + {1'b0, step_y};
      hi_step = step_r[WIDTH:1];
      lo_step = {step_r[0], lo_q[WIDTH-1:1]};
    end
  end

  // Load operands on start, otherwise iterate while the counter is non-zero
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    if (start) begin
      op_div_d = (op == OP_DIV);
      hi_d     = '0;
      lo_d     = (op == OP_DIV) ? a : b;
      opnd_d   = (op == OP_DIV) ? b : a;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Iteration state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
    end
  end

  // The step outputs are the final result on the last iteration edge
  assign finish = (cnt_q == CW'(1));
  assign res_hi = hi_step;
  assign res_lo = lo_step;

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execution unit: FSM, single-cycle ADD/SUB, result registers
import alu_pkg::*;

module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_alu,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_lo_q, result_lo_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             carry_q, carry_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             accept;
  logic             core_start;
  logic             core_finish;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic [WIDTH:0]   add_r;
  logic [WIDTH:0]   sub_r;

  // DONE accepts like IDLE so commands can run back-to-back
  assign accept     = load_alu && (state_q != ST_RUN);
  assign core_start = accept && ((alu_op == OP_MUL) || ((alu_op == OP_DIV) && (b != '0)));
  assign add_r      = {1'b0, a} + {1'b0, b};
  assign sub_r      = {1'b0, a} - {1'b0, b};

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (core_start),
    .op     (alu_op),
    .a      (a),
    .b      (b),
    .finish (core_finish),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  // Next-state and result update; results only move on a completion edge
  always_comb begin
    state_d       = state_q;
    result_lo_d   = result_lo_q;
    result_hi_d   = result_hi_q;
    carry_d       = carry_q;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      ST_RUN: begin
        if (core_finish) begin
          state_d       = ST_DONE;
          result_lo_d   = core_lo;
          result_hi_d   = core_hi;
          carry_d       = 1'b0;
          div_by_zero_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          case (alu_op)
            OP_ADD: begin
              state_d       = ST_DONE;
              result_lo_d   = add_r[WIDTH-1:0];
              result_hi_d   = '0;
              carry_d       = add_r[WIDTH];
              div_by_zero_d = 1'b0;
            end
            OP_SUB: begin
              state_d       = ST_DONE;
              result_lo_d   = sub_r[WIDTH-1:0];
              result_hi_d   = '0;
              carry_d       = sub_r[WIDTH];
              div_by_zero_d = 1'b0;
            end
            OP_MUL: begin
              state_d = ST_RUN;
            end
            default: begin
              if (b == '0) begin
                state_d       = ST_DONE;
                result_lo_d   = '1;
                result_hi_d   = a;
                carry_d       = 1'b0;
                div_by_zero_d = 1'b1;
              end else begin
                state_d = ST_RUN;
              end
            end
          endcase
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      result_lo_q   <= '0;
      result_hi_q   <= '0;
      carry_q       <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      result_lo_q   <= result_lo_d;
      result_hi_q   <= result_hi_d;
      carry_q       <= carry_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign result_lo   = result_lo_q;
  assign result_hi   = result_hi_q;
  assign carry       = carry_q;
  assign div_by_zero = div_by_zero_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed table-driven bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_alu;
  logic [1:0] alu_op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result_lo;
  logic [7:0] result_hi;
  logic       carry;
  logic       div_by_zero;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  alu_exec_unit #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_alu    (load_alu),
    .alu_op      (alu_op),
    .a           (a),
    .b           (b),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .carry       (carry),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       cy;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one command and wait (bounded) for done; lat counts edges after the accept edge
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output int nbusy);
    alu_op   = op;
    a        = av;
    b        = bv;
    load_alu = 1'b1;
    tick();
    load_alu = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
  endtask

  int lat;
  int nbusy;
  int seen;
  int ndone;
  int next_done;
  logic prev_done;

  initial begin
    vecs.push_back('{OP_ADD, 8'd200, 8'd100, 8'd44,  8'd0,   1'b1, 1'b0, 0});
    vecs.push_back('{OP_SUB, 8'd5,   8'd10,  8'd251, 8'd0,   1'b1, 1'b0, 0});
    vecs.push_back('{OP_SUB, 8'd10,  8'd5,   8'd5,   8'd0,   1'b0, 1'b0, 0});
    vecs.push_back('{OP_ADD, 8'd255, 8'd1,   8'd0,   8'd0,   1'b1, 1'b0, 0});
    vecs.push_back('{OP_ADD, 8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 0});
    vecs.push_back('{OP_MUL, 8'd3,   8'd4,   8'd12,  8'd0,   1'b0, 1'b0, 8});
    vecs.push_back('{OP_MUL, 8'd0,   8'd77,  8'd0,   8'd0,   1'b0, 1'b0, 8});
    vecs.push_back('{OP_MUL, 8'd16,  8'd32,  8'd0,   8'd2,   1'b0, 1'b0, 8});
    vecs.push_back('{OP_DIV, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 1'b0, 8});
    vecs.push_back('{OP_DIV, 8'd100, 8'd0,   8'd255, 8'd100, 1'b0, 1'b1, 0});
    vecs.push_back('{OP_ADD, 8'd1,   8'd2,   8'd3,   8'd0,   1'b0, 1'b0, 0});
    vecs.push_back('{OP_DIV, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 8});
    vecs.push_back('{OP_DIV, 8'd7,   8'd200, 8'd0,   8'd7,   1'b0, 1'b0, 8});
    vecs.push_back('{OP_DIV, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b0, 8});

    reset    = 1'b1;
    load_alu = 1'b0;
    alu_op   = OP_ADD;
    a        = '0;
    b        = '0;
    repeat (2) tick();
    chk("reset lo",    int'(result_lo),   0);
    chk("reset hi",    int'(result_hi),   0);
    chk("reset carry", int'(carry),       0);
    chk("reset dbz",   int'(div_by_zero), 0);
    chk("reset busy",  int'(busy),        0);
    chk("reset done",  int'(done),        0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, lat, nbusy);
      chk($sformatf("v%0d latency", i),      lat,                      vecs[i].lat);
      chk($sformatf("v%0d busy cycles", i),  nbusy,                    vecs[i].lat);
      chk($sformatf("v%0d busy at done", i), int'(busy),               0);
      chk($sformatf("v%0d result_lo", i),    int'(result_lo),          int'(vecs[i].lo));
      chk($sformatf("v%0d result_hi", i),    int'(result_hi),          int'(vecs[i].hi));
      chk($sformatf("v%0d carry", i),        int'(carry),              int'(vecs[i].cy));
      chk($sformatf("v%0d div_by_zero", i),  int'(div_by_zero),        int'(vecs[i].dz));
      tick();
      chk($sformatf("v%0d done pulse", i),   int'(done),               0);
      chk($sformatf("v%0d hold lo", i),      int'(result_lo),          int'(vecs[i].lo));
    end

    // MUL 255*255 with an ADD command presented while busy
    alu_op   = OP_MUL;
    a        = 8'd255;
    b        = 8'd255;
    load_alu = 1'b1;
    tick();
    lat      = 0;
    alu_op   = OP_ADD;
    a        = 8'd1;
    b        = 8'd1;
    repeat (2) begin tick(); lat++; end
    load_alu = 1'b0;
    while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("mul ignore latency", lat,              8);
    chk("mul ignore hi",      int'(result_hi),  8'hFE);
    chk("mul ignore lo",      int'(result_lo),  8'h01);
    tick();
    chk("mul ignore no extra cmd", int'(done | busy), 0);

    // Reset four cycles into MUL 12x12
    alu_op   = OP_MUL;
    a        = 8'd12;
    b        = 8'd12;
    load_alu = 1'b1;
    tick();
    load_alu = 1'b0;
    repeat (3) tick();
    chk("pre-reset busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midrun reset lo",    int'(result_lo),   0);
    chk("midrun reset hi",    int'(result_hi),   0);
    chk("midrun reset carry", int'(carry),       0);
    chk("midrun reset busy",  int'(busy),        0);
    chk("midrun reset done",  int'(done),        0);
    tick();
    reset = 1'b0;
    seen  = 0;
    repeat (12) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    chk("no done after reset", seen, 0);
    run_cmd(OP_ADD, 8'd1, 8'd1, lat, nbusy);
    chk("post-reset add latency", lat,             0);
    chk("post-reset add lo",      int'(result_lo), 2);

    // load_alu held high with MUL 3x4: done every 9 cycles, no idle gap
    tick();
    alu_op    = OP_MUL;
    a         = 8'd3;
    b         = 8'd4;
    load_alu  = 1'b1;
    tick();
    ndone     = 0;
    next_done = 8;
    prev_done = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (prev_done) chk($sformatf("held busy after done %0d", ndone), int'(busy), 1);
      if (done === 1'b1) begin
        chk($sformatf("held done cycle %0d", ndone), i, next_done);
        chk($sformatf("held result %0d", ndone), int'(result_lo), 12);
        ndone++;
        next_done += 9;
      end
      prev_done = done;
      tick();
    end
    chk("held done count", ndone, 3);
    load_alu = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
